// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO drain controller: issues fifo_rd pops and hides the 1-cycle memory latency behind a 2-entry output buffer.
// Optional macro FIFO_RD_CNT_EN adds a 16-bit wrapping pop counter on port rd_count.
module fifo_rd_ctrl #(
  parameter int WORD_SIZE    = 6,
  parameter bit LOW_WM_STALL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_enable,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic                 fifo_almost_empty,
  input  logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_rd,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]          rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q;
  logic                 head_q, head_d;
  logic [WORD_SIZE-1:0] buf_q [2];
  logic                 pop;
  logic                 stall;
  logic                 tail;
  logic [2:0]           pending;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_q[head_q];
  assign busy      = (state_q != IDLE);
  assign pop       = out_valid & out_ready;
  assign stall     = LOW_WM_STALL & fifo_almost_empty & ~flush;

  // Words that will sit in the buffer after this edge, before any new read.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd = ~reset & (state_q == RUN) & ~fifo_empty & ~stall & (pending < 3'd2);

  // Tail slot for the arriving word; with occ==1 and a same-cycle pop this is also the new head.
  assign tail = head_q ^ (occ_q == 2'd1);

  always_comb begin
    occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    head_d = head_q ^ pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd;
      head_q     <= head_d;
      if (inflight_q) buf_q[tail] <= fifo_data_out;
      case (state_q)
        IDLE:    if (rd_enable | flush) state_q <= RUN;
        RUN:     if (~rd_enable & ~flush) state_q <= DRAIN;
        DRAIN: begin
          // No reads issue in DRAIN, so the next in-flight bit is always 0 here.
          if (rd_enable | flush)   state_q <= RUN;
          else if (occ_d == 2'd0)  state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    rd_count_q <= 16'd0;
    else if (pop) rd_count_q <= rd_count_q + 16'd1;
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO plus a latency/ordering model checked every cycle, and directed cycle tables.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_enable = 1'b0;
  logic       flush = 1'b0;
  logic       fifo_empty;
  logic       fifo_almost_empty = 1'b0;
  logic [5:0] fifo_data_out = 6'd0;
  logic       fifo_rd;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  fifo_rd_ctrl #(.WORD_SIZE(6), .LOW_WM_STALL(1'b1)) dut (
    .clk(clk), .reset(reset), .rd_enable(rd_enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd(fifo_rd), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef FIFO_RD_CNT_EN
    , .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: data appears the cycle after fifo_rd, empty flag follows the pointers.
  logic [5:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data_out <= mem[rd_ptr & 63];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic load(input logic [5:0] d);
    mem[wr_ptr & 63] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Model: every read word becomes visible two cycles after its read, and leaves in read order.
  typedef struct { logic [5:0] d; int t; } ent_t;
  ent_t model_q[$];
  int   pops_m = 0;

  function automatic bit model_vld();
    return (model_q.size() > 0) && (model_q[0].t <= cyc);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
      pops_m <= 0;
    end else begin
      if (model_vld() && out_ready) begin
        void'(model_q.pop_front());
        pops_m <= pops_m + 1;
      end
      if (fifo_rd) model_q.push_back('{d: mem[rd_ptr & 63], t: cyc + 2});
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit ev;
    ev = model_vld();
    chk("m.out_valid", out_valid, ev);
    if (ev) chk("m.out_data", out_data, model_q[0].d);
    chk("m.rd_while_empty", fifo_rd & fifo_empty, 0);
    chk("m.buf_bound", (model_q.size() + fifo_rd - (ev & out_ready)) <= 2, 1);
    if (fifo_almost_empty && !flush) chk("m.stall", fifo_rd, 0);
  end

  task automatic dchk(input string nm, input logic rd, input logic vld,
                      input logic [5:0] d, input logic b);
    @(negedge clk);
    chk({nm, ".fifo_rd"}, fifo_rd, rd);
    chk({nm, ".out_valid"}, out_valid, vld);
    if (vld) chk({nm, ".out_data"}, out_data, d);
    chk({nm, ".busy"}, busy, b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.fifo_rd", fifo_rd, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_enable = 1'b1;
    dchk("t1.idle", 0, 0, 0, 0);

    // Three words, consumer always ready.
    load(6'h11); load(6'h22); load(6'h33); out_ready = 1'b1;
    dchk("t1.c0", 1, 0, 0, 1);
    dchk("t1.c1", 1, 0, 0, 1);
    dchk("t1.c2", 1, 1, 6'h11, 1);
    dchk("t1.c3", 0, 1, 6'h22, 1);
    dchk("t1.c4", 0, 1, 6'h33, 1);
    dchk("t1.c5", 0, 0, 0, 1);

    // Backpressure: two reads then hold, release at cycle 5.
    load(6'h01); load(6'h02); load(6'h03); load(6'h04); out_ready = 1'b0;
    dchk("t2.c0", 1, 0, 0, 1);
    dchk("t2.c1", 1, 0, 0, 1);
    dchk("t2.c2", 0, 1, 6'h01, 1);
    dchk("t2.c3", 0, 1, 6'h01, 1);
    dchk("t2.c4", 0, 1, 6'h01, 1);
    out_ready = 1'b1;
    dchk("t2.c5", 1, 1, 6'h01, 1);
    dchk("t2.c6", 1, 1, 6'h02, 1);
    dchk("t2.c7", 0, 1, 6'h03, 1);
    dchk("t2.c8", 0, 1, 6'h04, 1);
    dchk("t2.c9", 0, 0, 0, 1);

    // Drop rd_enable with a read in flight: two words delivered, 0x3F stays in the FIFO.
    load(6'h2A); load(6'h15); load(6'h3F);
    dchk("t3.c0", 1, 0, 0, 1);
    rd_enable = 1'b0;
    dchk("t3.c1", 1, 0, 0, 1);
    dchk("t3.c2", 0, 1, 6'h2A, 1);
    dchk("t3.c3", 0, 1, 6'h15, 1);
    dchk("t3.c4", 0, 0, 0, 0);
    dchk("t3.c5", 0, 0, 0, 0);

    // Low-watermark stall with two words present, then flush overrides it.
    load(6'h07); fifo_almost_empty = 1'b1; rd_enable = 1'b1;
    dchk("t4.c0", 0, 0, 0, 0);
    dchk("t4.c1", 0, 0, 0, 1);
    dchk("t4.c2", 0, 0, 0, 1);
    flush = 1'b1;
    dchk("t4.c3", 1, 0, 0, 1);
    dchk("t4.c4", 1, 0, 0, 1);
    dchk("t4.c5", 0, 1, 6'h3F, 1);
    dchk("t4.c6", 0, 1, 6'h07, 1);
    dchk("t4.c7", 0, 0, 0, 1);
    flush = 1'b0; fifo_almost_empty = 1'b0;

    // Asynchronous reset with a full buffer.
    load(6'h31); load(6'h32); load(6'h33); load(6'h34); out_ready = 1'b0;
    dchk("t5.c0", 1, 0, 0, 1);
    dchk("t5.c1", 1, 0, 0, 1);
    dchk("t5.c2", 0, 1, 6'h31, 1);
    dchk("t5.c3", 0, 1, 6'h31, 1);
    #2;
    chk("t5.pre.out_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("t5.rst.out_valid", out_valid, 0);
    chk("t5.rst.fifo_rd", fifo_rd, 0);
    chk("t5.rst.busy", busy, 0);
    chk("t5.rst.out_data", out_data, 0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    dchk("t5.r0", 0, 0, 0, 0);
    dchk("t5.r1", 1, 0, 0, 1);
    dchk("t5.r2", 1, 0, 0, 1);
    dchk("t5.r3", 0, 1, 6'h33, 1);
    dchk("t5.r4", 0, 1, 6'h34, 1);
    dchk("t5.r5", 0, 0, 0, 1);

`ifdef FIFO_RD_CNT_EN
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6.cnt_rst", rd_count, 0);
    for (int n = 0; n < 70000 && pops_m < 32'h10002; n++) begin
      if (wr_ptr - rd_ptr < 8) load(n[5:0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("t6.pop_budget", pops_m, 32'h10002);
    chk("t6.cnt_model", rd_count, pops_m & 16'hFFFF);
    chk("t6.cnt_wrap", rd_count, 2);
    @(posedge clk); #1;
    chk("t6.cnt_hold", rd_count, 2);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
